// File: rtl/logic_unit_serial.sv
// rtl/logic_unit_serial.sv - handshaked AND/OR/XOR/NOR unit, one SLICE-bit slice per clock
module logic_unit_serial #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic [CW-1:0]    cnt;

    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic [SLICE-1:0] slice_r;
    logic [WIDTH-1:0] result_next;

    // result_next is the result register with the current slice merged in, so the
    // last RUN edge can derive zero from the complete word.
    always_comb begin
        slice_a     = a_q[cnt*SLICE +: SLICE];
        slice_b     = b_q[cnt*SLICE +: SLICE];
        slice_r     = '0;
        case (op_q)
            2'b00:   slice_r = slice_a & slice_b;
            2'b01:   slice_r = slice_a | slice_b;
            2'b10:   slice_r = slice_a ^ slice_b;
            default: slice_r = ~(slice_a | slice_b);
        endcase
        result_next                      = result;
        result_next[cnt*SLICE +: SLICE]  = slice_r;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        op_q     <= op;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    result <= result_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        zero      <= (result_next == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/logic_unit_serial.md
# logic_unit_serial

Sequential, handshaked 32-bit logic unit that serves as the responder for the ALU operand driver. It accepts an operand pair and an operation code over a valid/ready input channel. It computes AND/OR/XOR/NOR one slice per clock and returns the result over a valid/ready output channel. It sits behind the ALU issue logic as the multi-cycle replacement for the combinational logic slices, and must be bit-exact with the combinational `Nor_32Bit`, And, Or and Xor blocks.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SLICE.
- SLICE, 4, bits processed per clock; N = WIDTH/SLICE cycles per operation (8 at defaults).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair and op are valid.
- in_ready  output  1  unit can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR.
- out_valid  output  1  result and zero are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  operation result.
- zero  output  1  1 when result == 0; meaningful only while out_valid.

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: slice processing.
  - DONE: out_valid=1.
- Reset (asynchronous, any state, including mid-RUN or mid-DONE): state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, slice counter=0, operand/op registers=0. An in-flight operation is discarded and no output is produced for it.
- IDLE -> RUN on an edge where in_valid & in_ready:
  - a, b and op are latched.
  - Counter is cleared.
  - Input changes after this edge have no effect.
- RUN, each edge:
  - Slice k (bits [k*SLICE +: SLICE]) is computed from the latched operands with the latched op and written into result bits [k*SLICE +: SLICE].
  - Counter increments.
  - On the edge that writes slice N-1, state becomes DONE and zero is computed from the complete result.
- DONE:
  - out_valid=1; result and zero are held stable until out_valid & out_ready is sampled on an edge.
  - That edge moves the state to IDLE and out_valid falls.
  - result keeps its last value in IDLE and is overwritten slice by slice during the next RUN.
- Only one operation is in flight at a time; in_ready=0 in RUN and DONE.
- in_valid asserted while in_ready=0 is ignored; the driver must hold a, b, op and in_valid until accepted.
- out_ready asserted in IDLE or RUN has no effect.
- Bit-exactness with the combinational blocks:
  - NOR = ~(a|b)
  - AND = a&b
  - OR = a|b
  - XOR = a^b
- No arithmetic; no carries between slices.

## Timing
- Accept edge E0 (in_valid & in_ready).
- Edges E1..EN process slices 0..N-1.
- out_valid is high from EN until the output-handshake edge.
- Minimum latency from accept edge to out_valid: N cycles (8 at defaults).
- With out_ready held high, out_valid is high for exactly one cycle; in_ready returns the cycle after the handshake edge.
- Minimum initiation interval: N+2 cycles (10 at defaults).
- No combinational path from inputs to outputs: in_ready, out_valid, result and zero are register outputs.
- Consumer backpressure (out_ready low) stalls indefinitely in DONE with outputs stable.
- Reset asserted at any point: outputs take reset values immediately, without waiting for a clock edge. Deassertion is followed by IDLE on the next edge.

## Test plan
- NOR, a=FFFFFFFF, b=00000000, out_ready=1 -> out_valid rises 8 cycles after accept; result=00000000, zero=1; in_ready=0 throughout RUN/DONE.
- Back-to-back NOR, one operation per accept, in_valid held high:
  - a=12311111, b=00100000 -> EDCEEEEE.
  - a=10000100, b=11000010 -> EEFFFEEF.
  - a=11111000, b=00001111 -> EEEEEEEE.
  - All results have zero=0. Accepts are spaced exactly 10 cycles apart.
- Ops on a=12311111, b=00100000: AND -> 00100000; OR -> 12311111. Ops on a=11111000, b=00001111: XOR -> 11110111.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> result/zero held constant and in_ready=0. Raise out_ready -> a single handshake edge, then in_ready=1 on the next cycle.
- Input stability:
  - Change a/b/op on the cycle after accept -> result reflects the latched values.
  - in_valid pulsed during RUN -> no second accept.
- Reset mid-RUN (after slice 3) -> outputs immediately 0, in_ready=1, no out_valid for the aborted operation. A new NOR a=FFFFFFFF, b=0 then completes correctly with result 00000000.
